// File: rtl/evg_seq.sv
// ---------------------------------------------------------------------------
// evg_seq -- event generator sequencer.
//
// Emits one event code per clock on `ev`. Sources, highest priority first:
//   1. the periodic sync event (sync_code, once every sync_prd cycles),
//   2. four delayed slot events armed by each sync tick (slot0..slot3),
//   3. a small software event queue (FIFO) fed by a valid/ready handshake.
// A grant in cycle n shows up on `ev` in cycle n+1. Code 0 means "no event".
//
// Ports:
//   clk        in   clock, everything on the rising edge
//   aresetn    in   synchronous active-low reset
//   ena        in   enables the period counter and slot timers
//   sync_code  in   code emitted on each sync tick (0 = tick without sync)
//   sync_prd   in   sync period in cycles (0 behaves as 1)
//   slot_code  in   per-slot code, 0 disables the slot
//   slot_dly   in   per-slot delay after the tick, in cycles
//   sw_valid   in   software push request
//   sw_ready   out  queue can accept a push
//   sw_code    in   software event code (0 is accepted and discarded)
//   ev         out  transmitted event code (registered)
//   sync       out  high while ev carries the sync code
//   lost_cnt   out  saturating count of slot events dropped by a new tick
// ---------------------------------------------------------------------------
module evg_seq #(
  parameter int EV_W       = 8,
  parameter int PRD_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  ena,
  input  logic [EV_W-1:0]       sync_code,
  input  logic [PRD_W-1:0]      sync_prd,
  input  logic [3:0][EV_W-1:0]  slot_code,
  input  logic [3:0][PRD_W-1:0] slot_dly,
  input  logic                  sw_valid,
  output logic                  sw_ready,
  input  logic [EV_W-1:0]       sw_code,
  output logic [EV_W-1:0]       ev,
  output logic                  sync,
  output logic [7:0]            lost_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PRD_W-1:0] PRD_ZERO = {PRD_W{1'b0}};
  localparam logic [PRD_W-1:0] PRD_ONE  = PRD_W'(1'b1);
  localparam logic [EV_W-1:0]  EV_ZERO  = {EV_W{1'b0}};
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1'b1);
  localparam logic [AW:0]      OCC_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]      OCC_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]      OCC_FULL = (AW+1)'(FIFO_DEPTH);

  // period counter
  logic [PRD_W-1:0] prd_m1_s;
  logic [PRD_W-1:0] cnt_r;
  logic             tick_s;
  logic             sync_req_s;

  // slots
  logic [3:0]            active_r;
  logic [3:0]            pend_r;
  logic [3:0][PRD_W-1:0] tmr_r;
  logic [3:0][EV_W-1:0]  code_r;
  logic [3:0]            load_s;
  logic [3:0]            dly0_s;
  logic [3:0]            now_s;
  logic [3:0]            req_s;
  logic [3:0]            drop_s;
  logic [3:0][EV_W-1:0]  sel_code_s;
  logic [2:0]            n_drop_s;
  logic [8:0]            lost_sum_s;
  logic [7:0]            lost_r;

  // software queue
  logic [EV_W-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     occ_r;
  logic            push_s;
  logic            pop_s;
  logic            fifo_req_s;

  // arbitration
  logic            found_s;
  logic            gnt_sync_s;
  logic [3:0]      gnt_slot_s;
  logic            gnt_fifo_s;
  logic [EV_W-1:0] gnt_code_s;

  // output registers
  logic [EV_W-1:0] ev_r;
  logic            sync_r;

  assign ev       = ev_r;
  assign sync     = sync_r;
  assign lost_cnt = lost_r;

  // Reload value; a period of 0 is folded onto 1 so the counter never underflows.
  always_comb begin
    prd_m1_s = PRD_ZERO;
    if (sync_prd == PRD_ZERO) begin
      prd_m1_s = PRD_ZERO;
    end else begin
      prd_m1_s = sync_prd - PRD_ONE;
    end
  end

  assign tick_s     = ena && (cnt_r == PRD_ZERO);
  assign sync_req_s = tick_s && (sync_code != EV_ZERO);

  // Period counter: held at the reload value while disabled or in reset.
  always_ff @(posedge clk) begin
    if (!aresetn || !ena) begin
      cnt_r <= prd_m1_s;
    end else if (cnt_r == PRD_ZERO) begin
      cnt_r <= prd_m1_s;
    end else begin
      cnt_r <= cnt_r - PRD_ONE;
    end
  end

  // Per-slot request decode. A zero delay requests in the tick cycle itself,
  // so its code must come straight from the input rather than the latched copy.
  always_comb begin
    load_s     = 4'b0000;
    dly0_s     = 4'b0000;
    now_s      = 4'b0000;
    req_s      = 4'b0000;
    sel_code_s = '{default: EV_ZERO};
    for (int i = 0; i < 4; i++) begin
      load_s[i] = tick_s && (slot_code[i] != EV_ZERO);
      dly0_s[i] = (slot_dly[i] == PRD_ZERO);
      now_s[i]  = load_s[i] && dly0_s[i];
      req_s[i]  = pend_r[i] || (active_r[i] && (tmr_r[i] == PRD_ZERO)) || now_s[i];
      if (now_s[i]) begin
        sel_code_s[i] = slot_code[i];
      end else begin
        sel_code_s[i] = code_r[i];
      end
    end
  end

  assign fifo_req_s = (occ_r != OCC_ZERO);

  // Fixed-priority grant: sync, slot0..slot3, then the queue head.
  always_comb begin
    found_s    = 1'b0;
    gnt_sync_s = 1'b0;
    gnt_slot_s = 4'b0000;
    gnt_fifo_s = 1'b0;
    gnt_code_s = EV_ZERO;
    if (sync_req_s) begin
      gnt_sync_s = 1'b1;
      gnt_code_s = sync_code;
      found_s    = 1'b1;
    end else begin
      found_s    = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (!found_s && req_s[i]) begin
        gnt_slot_s[i] = 1'b1;
        gnt_code_s    = sel_code_s[i];
        found_s       = 1'b1;
      end else begin
        gnt_slot_s[i] = 1'b0;
      end
    end
    if (!found_s && fifo_req_s) begin
      gnt_fifo_s = 1'b1;
      gnt_code_s = fifo_mem_r[rd_ptr_r];
    end else begin
      gnt_fifo_s = 1'b0;
    end
  end

  // A slot still holding an unsent event (timer running or request waiting)
  // when the next tick arrives loses that event.
  always_comb begin
    drop_s   = 4'b0000;
    n_drop_s = 3'd0;
    for (int i = 0; i < 4; i++) begin
      drop_s[i] = tick_s && (pend_r[i] || active_r[i]) && !gnt_slot_s[i];
      n_drop_s  = n_drop_s + {2'b00, drop_s[i]};
    end
    lost_sum_s = {1'b0, lost_r} + {6'b000000, n_drop_s};
  end

  // Slot timers and pending requests; all cleared when disabled.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!aresetn || !ena) begin
        active_r[i] <= 1'b0;
        pend_r[i]   <= 1'b0;
        tmr_r[i]    <= PRD_ZERO;
        code_r[i]   <= EV_ZERO;
      end else if (load_s[i]) begin
        code_r[i] <= slot_code[i];
        if (dly0_s[i]) begin
          active_r[i] <= 1'b0;
          tmr_r[i]    <= PRD_ZERO;
          pend_r[i]   <= !gnt_slot_s[i];
        end else begin
          // Tick cycle counts as timer value slot_dly, so store one less.
          active_r[i] <= 1'b1;
          tmr_r[i]    <= slot_dly[i] - PRD_ONE;
          pend_r[i]   <= 1'b0;
        end
      end else if (tick_s) begin
        active_r[i] <= 1'b0;
        pend_r[i]   <= 1'b0;
      end else begin
        pend_r[i] <= req_s[i] && !gnt_slot_s[i];
        if (active_r[i] && (tmr_r[i] == PRD_ZERO)) begin
          active_r[i] <= 1'b0;
        end else if (active_r[i]) begin
          tmr_r[i] <= tmr_r[i] - PRD_ONE;
        end else begin
          tmr_r[i] <= tmr_r[i];
        end
      end
    end
  end

  // Saturating lost-event counter.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      lost_r <= 8'd0;
    end else if (lost_sum_s > 9'd255) begin
      lost_r <= 8'hFF;
    end else begin
      lost_r <= lost_sum_s[7:0];
    end
  end

  // Ready looks only at registered occupancy, so a full queue refuses a
  // push even in the cycle it pops.
  assign sw_ready = aresetn && (occ_r != OCC_FULL);
  assign push_s   = sw_valid && sw_ready && (sw_code != EV_ZERO);
  assign pop_s    = gnt_fifo_s;

  // Queue storage (no reset needed, occupancy guards every read).
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= sw_code;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      occ_r    <= OCC_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_ONE;
        2'b01:   occ_r <= occ_r - OCC_ONE;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Registered event output, one cycle after the grant.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      ev_r   <= EV_ZERO;
      sync_r <= 1'b0;
    end else begin
      ev_r   <= gnt_code_s;
      sync_r <= gnt_sync_s;
    end
  end

endmodule

// File: tb/tb_evg_seq.sv
// ---------------------------------------------------------------------------
// tb_evg_seq -- self-checking bench for evg_seq.
// Expected events (code, sync flag, cycle) are pushed to a scoreboard queue
// as stimulus is applied; a negedge monitor pops and compares every nonzero
// ev, and flags expected events whose cycle has passed.
// Cycle numbering: `cyc` is the number of rising edges seen; inputs driven
// in cycle k are sampled by the edge that starts cycle k+1.
// ---------------------------------------------------------------------------
module tb_evg_seq;

  logic             clk = 1'b0;
  logic             aresetn;
  logic             ena;
  logic [7:0]       sync_code;
  logic [15:0]      sync_prd;
  logic [3:0][7:0]  slot_code;
  logic [3:0][15:0] slot_dly;
  logic             sw_valid;
  logic             sw_ready;
  logic [7:0]       sw_code;
  logic [7:0]       ev;
  logic             sync;
  logic [7:0]       lost_cnt;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int b;

  typedef struct {
    logic [7:0] code;
    logic       sy;
    int         at;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  evg_seq #(.EV_W(8), .PRD_W(16), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .ena       (ena),
    .sync_code (sync_code),
    .sync_prd  (sync_prd),
    .slot_code (slot_code),
    .slot_dly  (slot_dly),
    .sw_valid  (sw_valid),
    .sw_ready  (sw_ready),
    .sw_code   (sw_code),
    .ev        (ev),
    .sync      (sync),
    .lost_cnt  (lost_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_ev(input logic [7:0] c, input logic s, input int at);
    exp_t e;
    e.code = c;
    e.sy   = s;
    e.at   = at;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].at < cyc) begin
      check("missing_ev", 32'd0, {24'd0, sb_q[0].code});
      void'(sb_q.pop_front());
    end
    if (ev != 8'h00) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ev", {24'd0, ev}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("ev_code", {24'd0, ev}, {24'd0, mon_e.code});
        check("ev_sync", {31'd0, sync}, {31'd0, mon_e.sy});
        check("ev_cycle", cyc, mon_e.at);
      end
    end else if (sync) begin
      check("sync_without_ev", {31'd0, sync}, 32'd0);
    end
  end

  task automatic do_reset();
    aresetn = 1'b0;
    step(2);
    @(negedge clk);
    check("rst_ev", {24'd0, ev}, 32'd0);
    check("rst_sync", {31'd0, sync}, 32'd0);
    check("rst_lost", {24'd0, lost_cnt}, 32'd0);
    check("rst_ready", {31'd0, sw_ready}, 32'd0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, sw_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    aresetn   = 1'b0;
    ena       = 1'b0;
    sync_code = 8'h00;
    sync_prd  = 16'd4;
    slot_code = '0;
    slot_dly  = '0;
    sw_valid  = 1'b0;
    sw_code   = 8'h00;
    step(1);
    do_reset();

    // Plain sync stream, period 4.
    sync_prd  = 16'd4;
    sync_code = 8'h1A;
    step(1);
    b   = cyc;
    ena = 1'b1;
    for (int k = 1; k <= 3; k++) expect_ev(8'h1A, 1'b1, b + 4 * k);
    step(13);
    ena = 1'b0;
    step(6);

    // Delayed slots: two with equal delay, one with zero delay.
    sync_prd     = 16'd10;
    sync_code    = 8'h1A;
    slot_code[0] = 8'h20; slot_dly[0] = 16'd3;
    slot_code[1] = 8'h21; slot_dly[1] = 16'd3;
    slot_code[2] = 8'h30; slot_dly[2] = 16'd0;
    step(1);
    b   = cyc;
    ena = 1'b1;
    for (int k = 0; k < 2; k++) begin
      expect_ev(8'h1A, 1'b1, b + 9 + 10 * k + 1);
      expect_ev(8'h30, 1'b0, b + 9 + 10 * k + 2);
      expect_ev(8'h20, 1'b0, b + 9 + 10 * k + 4);
      expect_ev(8'h21, 1'b0, b + 9 + 10 * k + 5);
    end
    step(25);
    ena = 1'b0;
    step(4);
    @(negedge clk);
    check("lost_slots_ok", {24'd0, lost_cnt}, 32'd0);
    step(1);

    // Delay longer than the period: every tick after the first loses slot0.
    slot_code    = '0;
    slot_dly     = '0;
    sync_code    = 8'h00;
    sync_prd     = 16'd2;
    slot_code[0] = 8'h22;
    slot_dly[0]  = 16'd5;
    step(1);
    ena = 1'b1;
    step(20);
    ena = 1'b0;
    @(negedge clk);
    check("lost_after_10_ticks", {24'd0, lost_cnt}, 32'd9);
    step(1);
    ena = 1'b1;
    step(600);
    ena = 1'b0;
    @(negedge clk);
    check("lost_saturated", {24'd0, lost_cnt}, 32'd255);
    step(3);
    @(negedge clk);
    check("lost_hold_when_off", {24'd0, lost_cnt}, 32'd255);
    step(1);
    slot_code = '0;
    slot_dly  = '0;
    do_reset();

    // Queue fills while sync (period 0 -> every cycle) hogs the output.
    sync_prd  = 16'd0;
    sync_code = 8'h1B;
    step(1);
    b        = cyc;
    ena      = 1'b1;
    sw_valid = 1'b1;
    for (int k = 1; k <= 4; k++) expect_ev(8'h1B, 1'b1, b + k);
    for (int k = 0; k < 5; k++) expect_ev(8'h41 + 8'(k), 1'b0, b + 5 + k);
    for (int k = 0; k < 4; k++) begin
      sw_code = 8'h41 + 8'(k);
      @(negedge clk);
      check("ready_filling", {31'd0, sw_ready}, 32'd1);
      step(1);
    end
    ena     = 1'b0;
    sw_code = 8'h45;
    @(negedge clk);
    check("ready_full", {31'd0, sw_ready}, 32'd0);
    step(1);
    @(negedge clk);
    check("ready_after_pop", {31'd0, sw_ready}, 32'd1);
    step(1);
    sw_valid = 1'b0;
    step(4);
    sw_valid = 1'b1;
    sw_code  = 8'h00;
    @(negedge clk);
    check("ready_zero_code", {31'd0, sw_ready}, 32'd1);
    step(1);
    sw_valid = 1'b0;
    step(5);

    // Sync, slot0 and queue head contend; then reset mid-sequence.
    sync_prd     = 16'd3;
    sync_code    = 8'h1C;
    slot_code[0] = 8'h23;
    slot_dly[0]  = 16'd0;
    step(1);
    b   = cyc;
    ena = 1'b1;
    expect_ev(8'h1C, 1'b1, b + 3);
    expect_ev(8'h23, 1'b0, b + 4);
    expect_ev(8'h50, 1'b0, b + 5);
    expect_ev(8'h1C, 1'b1, b + 6);
    step(1);
    sw_valid = 1'b1;
    sw_code  = 8'h50;
    step(1);
    sw_valid = 1'b0;
    step(3);
    sw_valid = 1'b1;
    sw_code  = 8'h51;
    step(1);
    sw_valid = 1'b0;
    aresetn  = 1'b0;
    step(1);
    @(negedge clk);
    check("ev_after_midrst", {24'd0, ev}, 32'd0);
    check("sync_after_midrst", {31'd0, sync}, 32'd0);
    check("ready_in_midrst", {31'd0, sw_ready}, 32'd0);
    step(1);
    aresetn   = 1'b1;
    ena       = 1'b0;
    slot_code = '0;
    @(negedge clk);
    check("ready_post_midrst", {31'd0, sw_ready}, 32'd1);
    step(8);

    @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
